timer_cfg_arbiter: RTL and testbench
====================================

TIMER_CFG_ARBITER -- requirements
Module: timer_cfg_arbiter

Interface
REQ-001 Parameter MATCHES, default 2, number of compare matches (1..15) counted in RUN before a grant completes.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ0_VALID  input  1  requester 0 has a timer configuration pending.
REQ-005 REQ0_READY  output  1  requester 0 command accepted this cycle when REQ0_VALID is also high.
REQ-006 REQ0_PRE  input  8  requester 0 preset value.
REQ-007 REQ0_CMP  input  8  requester 0 compare value.
REQ-008 REQ0_SEL  input  1  requester 0 reload-source select.
REQ-009 REQ1_VALID, REQ1_READY, REQ1_PRE, REQ1_CMP, REQ1_SEL  same directions, widths and meanings for requester 1.
REQ-010 ABORT  input  1  cancel the active grant.
REQ-011 TMR_COUNT  input  8  timer counter value.
REQ-012 TMR_DATA2  output  8  load data to the timer.
REQ-013 TMR_LDCOMP  output  1  timer compare-register load strobe.
REQ-014 TMR_LDPRE  output  1  timer preset-register load strobe.
REQ-015 TMR_SEL  output  1  timer reload-source select.
REQ-016 BUSY  output  1  high in every state except IDLE.
REQ-017 OWNER  output  1  index of the granted requester; holds its last value in IDLE.
REQ-018 DONE  output  1  one-cycle pulse on normal completion.
REQ-019 ERR  output  1  one-cycle pulse on abort.

Function
REQ-020 The FSM SHALL have the states IDLE, LDCMP, LDPRE, RUN and FIN.
REQ-021 In IDLE, READY SHALL be combinational from the VALIDs and the round-robin pointer: a sole valid requester gets READY; when both are valid, the requester not granted last gets READY; at most one READY is high at a time.
REQ-022 READY SHALL be low in every state except IDLE.
REQ-023 On VALID&&READY in IDLE, the block SHALL latch PRE, CMP and SEL, set OWNER and the pointer to the winner, clear the match counter, and go to LDCMP.
REQ-024 LDCMP (1 cycle): TMR_LDCOMP=1, TMR_DATA2=latched CMP; next state LDPRE.
REQ-025 LDPRE (1 cycle): TMR_LDPRE=1, TMR_DATA2=latched PRE; next state RUN.
REQ-026 TMR_LDCOMP and TMR_LDPRE SHALL never both be high; TMR_DATA2 SHALL be 0 outside LDCMP and LDPRE.
REQ-027 TMR_SEL SHALL equal the latched SEL in LDCMP, LDPRE and RUN, and SHALL be 0 in IDLE and FIN.
REQ-028 In RUN, each cycle with TMR_COUNT == latched CMP SHALL increment the 4-bit match counter; consecutive equal cycles each count.
REQ-029 When the counter reaches MATCHES, the state SHALL go to FIN on the same edge; the match counter SHALL NOT wrap.
REQ-030 FIN (1 cycle): DONE=1; next state IDLE.
REQ-031 A new command SHALL be accepted in IDLE at the earliest, giving a minimum of 5 cycles from acceptance to the next acceptance when MATCHES=1 and the match occurs in the first RUN cycle.
REQ-032 ABORT high in LDCMP, LDPRE or RUN SHALL force IDLE on the next edge, pulse ERR for that one cycle, and suppress DONE.
REQ-033 ABORT SHALL take priority over a simultaneous final match, and SHALL be ignored in IDLE and FIN.
REQ-034 The round-robin pointer SHALL update only on acceptance; an aborted grant still counts as granted.
REQ-035 A requester whose VALID drops before acceptance SHALL be neither granted nor latched; VALID and data are allowed to change after acceptance without effect.

Reset
REQ-036 While RST is high, the state SHALL be IDLE and all outputs (REQn_READY excepted as combinational) SHALL be 0.
REQ-037 While RST is high, REQn_READY SHALL be forced to 0.
REQ-038 While RST is high, the match counter and latched values SHALL be 0, and the pointer SHALL favour requester 0 on the first tie.
REQ-039 RST asserted mid-operation SHALL abandon the grant immediately, with no DONE or ERR pulse.

Verification
REQ-040 Single request: REQ0 PRE=0x10 CMP=0x20 SEL=0 accepted -> TMR_LDCOMP with DATA2=0x20, then TMR_LDPRE with DATA2=0x10; TMR_COUNT drives 0x20 on two separate RUN cycles -> DONE one cycle later, OWNER=0.
REQ-041 Tie after reset: REQ0 and REQ1 both valid -> REQ0 granted first, then REQ1 after FIN; a second tie grants REQ0 again (alternation).
REQ-042 Abort: ABORT pulsed in the second RUN cycle -> ERR one cycle, no DONE, BUSY=0 next cycle; the pointer has advanced.
REQ-043 Back-to-back matches: MATCHES=2, TMR_COUNT held at CMP=0x05 -> FIN reached after exactly 2 RUN cycles.
REQ-044 Simultaneous ABORT and final match -> ERR=1, DONE=0.
REQ-045 RST asserted in LDPRE -> all outputs 0 asynchronously, no strobes after release until a new acceptance.

Source files
------------

// File: rtl/timer_cfg_arbiter.sv
// Two-requester round-robin arbiter that loads a timer compare/preset pair,
// then waits for a number of compare matches before releasing the grant.
module timer_cfg_arbiter #(
  parameter int MATCHES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [7:0] REQ0_PRE,
  input  logic [7:0] REQ0_CMP,
  input  logic       REQ0_SEL,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [7:0] REQ1_PRE,
  input  logic [7:0] REQ1_CMP,
  input  logic       REQ1_SEL,
  input  logic       ABORT,
  input  logic [7:0] TMR_COUNT,
  output logic [7:0] TMR_DATA2,
  output logic       TMR_LDCOMP,
  output logic       TMR_LDPRE,
  output logic       TMR_SEL,
  output logic       BUSY,
  output logic       OWNER,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    IDLE, LDCMP, LDPRE, RUN, FIN
  } state_t;

  localparam logic [3:0] NMATCH = 4'(MATCHES);

  state_t     state;
  logic       last;
  logic [7:0] pre_q;
  logic [7:0] cmp_q;
  logic       sel_q;
  logic [3:0] cnt;

  logic       accept;
  logic       win;
  logic [7:0] pre_in;
  logic [7:0] cmp_in;
  logic       sel_in;
  logic       hit;
  logic       final_hit;

  // last=1 means requester 1 was granted last, so requester 0 wins a tie
  always_comb begin
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    if (!RST && state == IDLE) begin
      REQ0_READY = REQ0_VALID && (!REQ1_VALID || last);
      REQ1_READY = REQ1_VALID && (!REQ0_VALID || !last);
    end
  end

  assign accept    = REQ0_READY || REQ1_READY;
  assign win       = REQ1_READY;
  assign pre_in    = win ? REQ1_PRE : REQ0_PRE;
  assign cmp_in    = win ? REQ1_CMP : REQ0_CMP;
  assign sel_in    = win ? REQ1_SEL : REQ0_SEL;
  assign hit       = TMR_COUNT == cmp_q;
  assign final_hit = hit && (cnt + 4'd1 == NMATCH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last       <= 1'b1;
      pre_q      <= '0;
      cmp_q      <= '0;
      sel_q      <= 1'b0;
      cnt        <= '0;
      TMR_DATA2  <= '0;
      TMR_LDCOMP <= 1'b0;
      TMR_LDPRE  <= 1'b0;
      TMR_SEL    <= 1'b0;
      BUSY       <= 1'b0;
      OWNER      <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= LDCMP;
            OWNER      <= win;
            last       <= win;
            pre_q      <= pre_in;
            cmp_q      <= cmp_in;
            sel_q      <= sel_in;
            cnt        <= '0;
            BUSY       <= 1'b1;
            TMR_LDCOMP <= 1'b1;
            TMR_DATA2  <= cmp_in;
            TMR_SEL    <= sel_in;
          end
        end
        LDCMP, LDPRE, RUN: begin
          if (ABORT) begin
            state      <= IDLE;
            ERR        <= 1'b1;
            BUSY       <= 1'b0;
            TMR_LDCOMP <= 1'b0;
            TMR_LDPRE  <= 1'b0;
            TMR_DATA2  <= '0;
            TMR_SEL    <= 1'b0;
          end else if (state == LDCMP) begin
            state      <= LDPRE;
            TMR_LDCOMP <= 1'b0;
            TMR_LDPRE  <= 1'b1;
            TMR_DATA2  <= pre_q;
          end else if (state == LDPRE) begin
            state     <= RUN;
            TMR_LDPRE <= 1'b0;
            TMR_DATA2 <= '0;
          end else if (hit) begin
            cnt <= cnt + 4'd1;
            if (final_hit) begin
              state   <= FIN;
              DONE    <= 1'b1;
              TMR_SEL <= 1'b0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cfg_arbiter.sv
// Directed vector bench for timer_cfg_arbiter with MATCHES=2.
// Bundle: {r0,r1,ldcomp,ldpre,data[7:0],sel,busy,owner,done,err}.
module tb_timer_cfg_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ0_VALID, REQ0_READY, REQ0_SEL;
  logic       REQ1_VALID, REQ1_READY, REQ1_SEL;
  logic [7:0] REQ0_PRE, REQ0_CMP, REQ1_PRE, REQ1_CMP;
  logic       ABORT;
  logic [7:0] TMR_COUNT, TMR_DATA2;
  logic       TMR_LDCOMP, TMR_LDPRE, TMR_SEL;
  logic       BUSY, OWNER, DONE, ERR;

  timer_cfg_arbiter #(.MATCHES(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_PRE(REQ0_PRE), .REQ0_CMP(REQ0_CMP), .REQ0_SEL(REQ0_SEL),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_PRE(REQ1_PRE), .REQ1_CMP(REQ1_CMP), .REQ1_SEL(REQ1_SEL),
    .ABORT(ABORT), .TMR_COUNT(TMR_COUNT), .TMR_DATA2(TMR_DATA2),
    .TMR_LDCOMP(TMR_LDCOMP), .TMR_LDPRE(TMR_LDPRE),
    .TMR_SEL(TMR_SEL), .BUSY(BUSY), .OWNER(OWNER),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic        ab;
    logic [7:0]  cnt;
    logic [16:0] exp;
  } vec_t;

  vec_t q[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic logic [16:0] e(
    input logic r0, r1, ldc, ldp,
    input logic [7:0] d,
    input logic s, b, o, dn, er);
    return {r0, r1, ldc, ldp, d, s, b, o, dn, er};
  endfunction

  function automatic logic [16:0] outs(input logic r0, r1);
    return {r0, r1, TMR_LDCOMP, TMR_LDPRE, TMR_DATA2,
            TMR_SEL, BUSY, OWNER, DONE, ERR};
  endfunction

  task automatic add(input logic rst, v0, v1, ab,
                     input logic [7:0] cnt,
                     input logic [16:0] exp);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1;
    v.ab = ab; v.cnt = cnt; v.exp = exp;
    q.push_back(v);
  endtask

  task automatic chk(input string n,
                     input logic [16:0] a, w);
    nvec++;
    if (a !== w) begin
      nbad++;
      $display("FAIL %s got %h want %h", n, a, w);
    end
  endtask

  logic [16:0] z;
  logic r0s, r1s;

  initial begin
    z = '0;
    REQ0_PRE = 8'h10; REQ0_CMP = 8'h20; REQ0_SEL = 1'b0;
    REQ1_PRE = 8'h33; REQ1_CMP = 8'h05; REQ1_SEL = 1'b1;
    RST = 1'b1; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    ABORT = 1'b0; TMR_COUNT = 8'h00;
    #1 chk("reset_state", outs(REQ0_READY, REQ1_READY), z);

    // single request, two separate matches
    add(0,1,0,0,8'h00, e(1,0,1,0,8'h20,0,1,0,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,1,8'h10,0,1,0,0,0));
    add(0,0,0,0,8'h20, e(0,0,0,0,8'h00,0,1,0,0,0));
    add(0,0,0,0,8'h20, e(0,0,0,0,8'h00,0,1,0,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,0,8'h00,0,1,0,0,0));
    add(0,0,0,0,8'h20, e(0,0,0,0,8'h00,0,1,0,1,0));
    add(0,0,0,0,8'h00, z);
    // reset, then tie -> req0, then tie -> req1
    add(1,1,1,0,8'h00, z);
    add(0,1,1,0,8'h00, e(1,0,1,0,8'h20,0,1,0,0,0));
    add(0,1,1,0,8'h00, e(0,0,0,1,8'h10,0,1,0,0,0));
    add(0,1,1,0,8'h00, e(0,0,0,0,8'h00,0,1,0,0,0));
    add(0,1,1,0,8'h20, e(0,0,0,0,8'h00,0,1,0,0,0));
    add(0,1,1,0,8'h20, e(0,0,0,0,8'h00,0,1,0,1,0));
    add(0,1,1,0,8'h00, z);
    add(0,1,1,0,8'h00, e(0,1,1,0,8'h05,1,1,1,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,1,8'h33,1,1,1,0,0));
    add(0,0,0,0,8'h05, e(0,0,0,0,8'h00,1,1,1,0,0));
    add(0,0,0,0,8'h05, e(0,0,0,0,8'h00,1,1,1,0,0));
    add(0,0,0,0,8'h05, e(0,0,0,0,8'h00,0,1,1,1,0));
    // abort in FIN is ignored
    add(0,0,0,1,8'h00, e(0,0,0,0,8'h00,0,0,1,0,0));
    // third tie alternates back to req0, aborted in 2nd RUN cycle
    add(0,1,1,0,8'h00, e(1,0,1,0,8'h20,0,1,0,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,1,8'h10,0,1,0,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,0,8'h00,0,1,0,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,0,8'h00,0,1,0,0,0));
    add(0,0,0,1,8'h00, e(0,0,0,0,8'h00,0,0,0,0,1));
    // pointer advanced past the aborted grant
    add(0,1,1,0,8'h00, e(0,1,1,0,8'h05,1,1,1,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,1,8'h33,1,1,1,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,0,8'h00,1,1,1,0,0));
    add(0,0,0,0,8'h05, e(0,0,0,0,8'h00,1,1,1,0,0));
    // abort together with the final match
    add(0,0,0,1,8'h05, e(0,0,0,0,8'h00,0,0,1,0,1));
    add(0,0,0,1,8'h05, e(0,0,0,0,8'h00,0,0,1,0,0));
    // reset during LDPRE, then quiet
    add(0,1,0,0,8'h00, e(1,0,1,0,8'h20,0,1,0,0,0));
    add(0,0,0,0,8'h00, e(0,0,0,1,8'h10,0,1,0,0,0));
    add(1,0,0,0,8'h00, z);
    add(0,0,0,0,8'h20, z);
    add(0,0,0,0,8'h20, z);
    add(0,1,1,0,8'h00, e(1,0,1,0,8'h20,0,1,0,0,0));

    @(posedge CLK); #1;
    foreach (q[i]) begin
      RST = q[i].rst; REQ0_VALID = q[i].v0;
      REQ1_VALID = q[i].v1; ABORT = q[i].ab;
      TMR_COUNT = q[i].cnt;
      #1;
      r0s = REQ0_READY; r1s = REQ1_READY;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d", i), outs(r0s, r1s), q[i].exp);
    end

    // asynchronous reset while REQ1 is in LDPRE
    RST = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    ABORT = 1'b0; TMR_COUNT = 8'h00;
    @(posedge CLK); #1;
    RST = 1'b0; REQ1_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ1_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("ldpre_before_rst", outs(1'b0, 1'b0),
        e(0,0,0,1,8'h33,1,1,1,0,0));
    #2 RST = 1'b1;
    #1 chk("async_rst", outs(REQ0_READY, REQ1_READY), z);
    @(posedge CLK); #1;
    RST = 1'b0; TMR_COUNT = 8'h05;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("quiet%0d", k), outs(REQ0_READY, REQ1_READY), z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
